// File: rtl/cpu_writeback_unit.sv
// Register-file write-port driver: arbitrates memory load returns, a one-entry ALU skid
// buffer and fresh ALU results, and tracks outstanding load tags. Option macro: WB_LOAD_FORWARD_EN.
module cpu_writeback_unit #(
  parameter int LQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_load,
  input  logic [2:0]  i_ex_rw,
  input  logic [15:0] i_ex_data,
  output logic        o_ex_ready,
  input  logic        i_mem_rvalid,
  input  logic [15:0] i_mem_rdata,
  output logic [2:0]  o_rw,
  output logic [15:0] o_rw_data,
  output logic        o_rw_en,
  input  logic [2:0]  i_rx,
  input  logic [2:0]  i_ry,
  output logic        o_rx_busy,
  output logic        o_ry_busy,
  output logic        o_err
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;

`ifdef WB_LOAD_FORWARD_EN
  localparam bit FORWARD = 1'b1;
`else
  localparam bit FORWARD = 1'b0;
`endif

  logic [2:0]    lq_tag [LQ_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          skid_valid;
  logic [2:0]    skid_rw;
  logic [15:0]   skid_data;

  logic [LQ_DEPTH-1:0] entry_valid;
  logic ex_hit;
  logic rx_hit;
  logic ry_hit;
  logic ex_fire;
  logic alu_fire;
  logic load_fire;
  logic mem_pop;
  logic lq_full;

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    entry_valid = '0;
    ex_hit      = 1'b0;
    rx_hit      = 1'b0;
    ry_hit      = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      entry_valid[i] = CW'(PW'(PW'(i) - rd_ptr)) < count;
      if (entry_valid[i] && lq_tag[i] == i_ex_rw) ex_hit = 1'b1;
      if (entry_valid[i] && lq_tag[i] == i_rx)    rx_hit = 1'b1;
      if (entry_valid[i] && lq_tag[i] == i_ry)    ry_hit = 1'b1;
    end
  end

  // Execute handshake: a transfer happens in exactly the cycles where i_ex_valid and
  // o_ex_ready are both high; o_ex_ready never depends on i_ex_valid.
  assign lq_full    = (count == CW'(LQ_DEPTH));
  assign o_ex_ready = !skid_valid
                   && !(i_ex_is_load && lq_full)
                   && !(!i_ex_is_load && ex_hit);

  assign ex_fire   = i_ex_valid && o_ex_ready;
  assign alu_fire  = ex_fire && !i_ex_is_load;
  assign load_fire = ex_fire && i_ex_is_load;
  assign mem_pop   = i_mem_rvalid && (count != '0);

  assign o_rx_busy = rx_hit || (o_rw_en && (o_rw == i_rx) && !FORWARD);
  assign o_ry_busy = ry_hit || (o_rw_en && (o_rw == i_ry) && !FORWARD);

  always_ff @(posedge clk) begin
    if (load_fire) lq_tag[wr_ptr] <= i_ex_rw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      skid_valid <= 1'b0;
      skid_rw    <= '0;
      skid_data  <= '0;
      o_rw_en    <= 1'b0;
      o_rw       <= '0;
      o_rw_data  <= '0;
      o_err      <= 1'b0;
    end else begin
      if (load_fire) wr_ptr <= wr_ptr + PW'(1);
      if (mem_pop)   rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(load_fire) - CW'(mem_pop);

      // A return with nothing outstanding is flagged and otherwise ignored.
      if (i_mem_rvalid && count == '0) o_err <= 1'b1;

      if (mem_pop) begin
        o_rw_en   <= 1'b1;
        o_rw      <= lq_tag[rd_ptr];
        o_rw_data <= i_mem_rdata;
      end else if (skid_valid) begin
        o_rw_en   <= 1'b1;
        o_rw      <= skid_rw;
        o_rw_data <= skid_data;
      end else if (alu_fire) begin
        o_rw_en   <= 1'b1;
        o_rw      <= i_ex_rw;
        o_rw_data <= i_ex_data;
      end else begin
        o_rw_en   <= 1'b0;
      end

      // Skid is never valid when an ALU result fires, since it holds o_ex_ready low.
      if (alu_fire && mem_pop) begin
        skid_valid <= 1'b1;
        skid_rw    <= i_ex_rw;
        skid_data  <= i_ex_data;
      end else if (!mem_pop) begin
        skid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cpu_writeback_unit.md
# cpu_writeback_unit

Write-side driver for the CPU's 8×16-bit general-purpose register file. It accepts results from the execute stage and load data returning from memory, and arbitrates them onto the register file's single write port (`o_rw`, `o_rw_data`, `o_rw_en`). It also keeps an in-order scoreboard of outstanding loads, so decode can stall on registers whose value has not yet arrived.

## Interface
Parameters:
- `LQ_DEPTH`, default 4: load-queue entries, meaning the maximum number of outstanding loads; power of 2, ≥2.

Ports:
- `clk` in 1: the block's single clock.
- `reset` in 1: synchronous, active-high reset.
- `i_ex_valid` in 1: execute result or load issue present.
- `i_ex_is_load` in 1: 1 = load issued (destination tag only, no data); 0 = ALU/PC result.
- `i_ex_rw` in 3: destination register.
- `i_ex_data` in 16: ALU result; ignored when `i_ex_is_load`=1.
- `o_ex_ready` out 1: transfer occurs when `i_ex_valid && o_ex_ready`.
- `i_mem_rvalid` in 1: load data returning; cannot be stalled.
- `i_mem_rdata` in 16: load data.
- `o_rw` out 3: register file write address.
- `o_rw_data` out 16: register file write data.
- `o_rw_en` out 1: register file write enable.
- `i_rx` in 3, `i_ry` in 3: decode source registers to check.
- `o_rx_busy` out 1, `o_ry_busy` out 1: the source has a pending load write.
- `o_err` out 1: sticky flag; a memory return arrived with the load queue empty.

## Operation
- **Load queue:** circular FIFO of 3-bit destination tags, with read/write pointers and a count.
  - Push on an accepted load.
  - Pop on `i_mem_rvalid`.
  - Loads return in issue order.
  - Push and pop in the same cycle are allowed.
- **Write port:** registered. `o_rw`/`o_rw_data`/`o_rw_en` are loaded each cycle from the winning source:
  - Priority 1: memory return. `o_rw` = popped tag, `o_rw_data` = `i_mem_rdata`.
  - Priority 2: skid buffer.
  - Priority 3: an ALU result accepted this cycle.
  - If no source is present, `o_rw_en` = 0 and `o_rw`/`o_rw_data` hold their last values.
- **Skid buffer:** one entry. It captures an ALU result accepted in a cycle where memory wins the port. It drains on the first cycle with no memory return.
- **`o_ex_ready`** is combinational. It equals 1 unless any of the following holds:
  - the skid buffer is valid;
  - `i_ex_is_load`=1 and count == `LQ_DEPTH` (a same-cycle pop grants no credit);
  - `i_ex_is_load`=0 and `i_ex_rw` matches any valid queue tag (WAW against a pending load).
- **Load after load:** a load to a register that already has a load pending is permitted, because returns are in order.
- **Busy:** `o_rx_busy` = `i_rx` matches any valid queue tag, OR (`o_rw_en` && `o_rw`==`i_rx` && forwarding disabled). `o_ry_busy` is defined the same way with `i_ry`.
- **Unexpected return:** `i_mem_rvalid` while count==0 sets `o_err`; no write is issued and no pointer moves.
- **Reset values:**
  - `o_rw_en`=0, `o_rw`=0, `o_rw_data`=0.
  - Queue empty, pointers=0, skid buffer invalid.
  - `o_err`=0.
  - `o_rx_busy`=`o_ry_busy`=0.
  - `o_ex_ready`=1 (for an ALU transfer).
- **Reset mid-operation:** pending tags and the skid entry are discarded. The register file receives no write in the reset cycle.

## Timing
- ALU result accepted in cycle N: `o_rw_en`=1 in cycle N+1, unless it collides with a memory return. In a collision it is skidded and written in the first cycle after N+1 that has no memory return.
- Memory return in cycle N: write in cycle N+1, and the tag leaves the queue at the end of cycle N.
- Load accepted in cycle N: `o_rx_busy` for its destination goes high in cycle N+1.
- Back-to-back memory returns keep the skid buffer occupied and `o_ex_ready` low for every cycle of the burst.
- Throughput: one register write per cycle.

## Configuration
- `WB_LOAD_FORWARD_EN` defined:
  - The register file bypasses write data to its read ports in the write cycle, so busy deasserts in the cycle the load write is on the port.
  - Load return in cycle N: busy is low from N+1.
- `WB_LOAD_FORWARD_EN` undefined:
  - Busy also covers the write cycle.
  - Load return in cycle N: busy is low from N+2.

## Test plan
- **ALU write:** ALU result r3=0x1234 accepted in cycle 5 → cycle 6 shows `o_rw_en`=1, `o_rw`=3, `o_rw_data`=0x1234; cycle 7 shows `o_rw_en`=0.
- **Collision:** load to r2 issued; in cycle 10, ALU r4=0x00AA coincides with return 0xBEEF → cycle 11 writes r2=0xBEEF, cycle 12 writes r4=0x00AA, and `o_ex_ready`=0 in cycle 11.
- **Queue full:** 4 loads (r1,r2,r1,r5) issued, then a fifth load → `o_ex_ready`=0. Returns 0x11,0x22,0x33,0x55 then write r1,r2,r1,r5 in order, and r1 busy stays high until its second return.
- **WAW:** load to r6 pending, ALU to r6 presented → `o_ex_ready`=0 until the return. Then the ALU result is accepted and written after the load value.
- **Forwarding macro:** load to r7 returns in cycle 20 → `o_rx_busy` (`i_rx`=7) is low in cycle 21 with `WB_LOAD_FORWARD_EN` defined, and low only from cycle 22 without it.
- **Reset and error:** reset asserted with 2 loads pending → busy=0 and the queue is empty; a subsequent `i_mem_rvalid` sets `o_err`=1 with no write, and it stays set until the next reset.
